// File: rtl/id_hazard_stall_unit.sv
// id_hazard_stall_unit: decode-stage RAW stall, IF hold and pipeline freeze for a pipeline without forwarding,
// tracking in-flight destinations in a shadow of ID/EX, EX/MEM, MEM/WB plus a saturating stall counter.
module id_hazard_stall_unit #(
   parameter bit WB_WRITE_FIRST = 1'b0,
   parameter int COUNT_WIDTH    = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   id_readsRs,
   input  logic [4:0]             id_rs,
   input  logic                   id_readsRt,
   input  logic [4:0]             id_rt,
   input  logic                   id_shouldWriteRegister,
   input  logic [4:0]             id_registerWriteAddress,
   input  logic                   mem_busy,
   output logic                   id_shouldStall,
   output logic                   if_shouldHold,
   output logic                   pipe_freeze,
   output logic [1:0]             hazard_stage,
   output logic [COUNT_WIDTH-1:0] stallCount
);
   logic [5:0] r_sh_ex, r_sh_mem, r_sh_wb;
   logic [COUNT_WIDTH-1:0] r_cnt;
   logic w_hit_ex, w_hit_mem, w_hit_wb, w_raw;

   // Entry layout is {we, addr}; $0 is hardwired and never a hazard.
   function automatic logic f_hit(input logic [5:0] sh, input logic rrs, input logic [4:0] rs,
                                  input logic rrt, input logic [4:0] rt);
      return sh[5] && sh[4:0] != 5'd0 && ((rrs && rs == sh[4:0]) || (rrt && rt == sh[4:0]));
   endfunction

   assign w_hit_ex  = f_hit(r_sh_ex, id_readsRs, id_rs, id_readsRt, id_rt);
   assign w_hit_mem = f_hit(r_sh_mem, id_readsRs, id_rs, id_readsRt, id_rt);
   assign w_hit_wb  = !WB_WRITE_FIRST && f_hit(r_sh_wb, id_readsRs, id_rs, id_readsRt, id_rt);
   assign w_raw     = w_hit_ex | w_hit_mem | w_hit_wb;

   assign pipe_freeze    = mem_busy;
   assign id_shouldStall = w_raw & ~mem_busy;
   assign if_shouldHold  = w_raw | mem_busy;
   assign hazard_stage   = w_hit_ex ? 2'd1 : w_hit_mem ? 2'd2 : w_hit_wb ? 2'd3 : 2'd0;
   assign stallCount     = r_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sh_ex  <= 6'd0;
         r_sh_mem <= 6'd0;
         r_sh_wb  <= 6'd0;
      end else if (!mem_busy) begin
         r_sh_ex  <= w_raw ? 6'd0 : {id_shouldWriteRegister, id_registerWriteAddress};
         r_sh_mem <= r_sh_ex;
         r_sh_wb  <= r_sh_mem;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         r_cnt <= '0;
      else if (id_shouldStall && r_cnt != '1)
         r_cnt <= r_cnt + COUNT_WIDTH'(1);
   end
endmodule

// File: tb/tb_id_hazard_stall_unit.sv
// tb_id_hazard_stall_unit: directed and random checks of two instances (WB compared / WB write-first with a
// 2-bit counter) against a pipeline-occupancy model.
module tb_id_hazard_stall_unit;
   logic clk = 1'b0;
   logic rst, mem_busy, rrs, rrt, we;
   logic [4:0] rs, rt, wd;
   logic s0, h0, f0, s1, h1, f1;
   logic [1:0] st0, st1, c1;
   logic [31:0] c0;
   int n_cmp = 0, n_err = 0;
   int m_st[2][3];
   int unsigned m_cnt[2];

   always #5 clk = ~clk;

   id_hazard_stall_unit #(.WB_WRITE_FIRST(1'b0), .COUNT_WIDTH(32)) dut0 (
      .clk(clk), .rst(rst), .id_readsRs(rrs), .id_rs(rs), .id_readsRt(rrt), .id_rt(rt),
      .id_shouldWriteRegister(we), .id_registerWriteAddress(wd), .mem_busy(mem_busy),
      .id_shouldStall(s0), .if_shouldHold(h0), .pipe_freeze(f0), .hazard_stage(st0), .stallCount(c0));

   id_hazard_stall_unit #(.WB_WRITE_FIRST(1'b1), .COUNT_WIDTH(2)) dut1 (
      .clk(clk), .rst(rst), .id_readsRs(rrs), .id_rs(rs), .id_readsRt(rrt), .id_rt(rt),
      .id_shouldWriteRegister(we), .id_registerWriteAddress(wd), .mem_busy(mem_busy),
      .id_shouldStall(s1), .if_shouldHold(h1), .pipe_freeze(f1), .hazard_stage(st1), .stallCount(c1));

   // Model: m_st[k] lists the destinations held by the instructions in EX, MEM, WB (0 = writes nothing).
   function automatic int exp_stage(int k);
      for (int s = 0; s < 3; s++)
         if (!(k == 1 && s == 2) && m_st[k][s] != 0 &&
             ((rrs && int'(rs) == m_st[k][s]) || (rrt && int'(rt) == m_st[k][s])))
            return s + 1;
      return 0;
   endfunction

   function automatic logic [4:0] exp_vec(int k);
      int g;
      g = exp_stage(k);
      return {g != 0 && !mem_busy, g != 0 || mem_busy, mem_busy, 2'(g)};
   endfunction

   task automatic tick();
      int g;
      int unsigned mx;
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         g  = exp_stage(k);
         mx = (k == 0) ? 32'hFFFF_FFFF : 32'd3;
         if (rst) begin
            m_st[k] = '{0, 0, 0};
            m_cnt[k] = 0;
         end else if (!mem_busy) begin
            if (g != 0 && m_cnt[k] != mx) m_cnt[k]++;
            m_st[k][2] = m_st[k][1];
            m_st[k][1] = m_st[k][0];
            m_st[k][0] = (g == 0 && we) ? int'(wd) : 0;
         end
      end
      @(negedge clk);
   endtask

   task automatic set(input logic r, input logic b, input logic a_rrs, input logic [4:0] a_rs,
                      input logic a_rrt, input logic [4:0] a_rt, input logic a_we, input logic [4:0] a_wd);
      rst = r; mem_busy = b; rrs = a_rrs; rs = a_rs; rrt = a_rrt; rt = a_rt; we = a_we; wd = a_wd;
      #1;
   endtask

   task automatic do_reset();
      set(1, 0, 0, 0, 0, 0, 0, 0);
      tick();
   endtask

   task automatic test_reset();
      set(1, 1, 0, 0, 0, 0, 0, 0);
      n_cmp++;
      if (f0 !== 1'b1 || f1 !== 1'b1) begin
         n_err++; $display("FAIL reset_freeze: freeze=%b/%b want 1/1", f0, f1);
      end
      tick();
      set(0, 0, 0, 0, 0, 0, 0, 0);
      n_cmp++;
      if ({s0, h0, f0, st0} !== 5'd0 || {s1, h1, f1, st1} !== 5'd0 || c0 !== 32'd0 || c1 !== 2'd0) begin
         n_err++; $display("FAIL reset_values: d0=%b/%b/%b/%0d cnt=%0d d1=%b/%b/%b/%0d cnt=%0d want all 0",
                           s0, h0, f0, st0, c0, s1, h1, f1, st1, c1);
      end
   endtask

   task automatic test_back_to_back();
      logic es0, es1;
      logic [1:0] est0, est1;
      do_reset();
      set(0, 0, 1, 3, 1, 4, 1, 1);
      n_cmp++;
      if (s0 !== 1'b0 || st0 !== 2'd0) begin
         n_err++; $display("FAIL b2b_producer: stall=%b stage=%0d want 0/0", s0, st0);
      end
      tick();
      for (int c = 0; c < 4; c++) begin
         set(0, 0, 1, 1, 1, 1, 1, 2);
         es0 = c < 3; est0 = c < 3 ? 2'(c + 1) : 2'd0;
         es1 = c < 2; est1 = c < 2 ? 2'(c + 1) : 2'd0;
         n_cmp++;
         if (s0 !== es0 || st0 !== est0) begin
            n_err++; $display("FAIL b2b_wb0 c%0d: stall=%b stage=%0d want %b/%0d", c, s0, st0, es0, est0);
         end
         n_cmp++;
         if (s1 !== es1 || st1 !== est1) begin
            n_err++; $display("FAIL b2b_wb1 c%0d: stall=%b stage=%0d want %b/%0d", c, s1, st1, es1, est1);
         end
         n_cmp++;
         if ({s0, h0, f0, st0} !== exp_vec(0)) begin
            n_err++; $display("FAIL b2b_model c%0d: got %b want %b", c, {s0, h0, f0, st0}, exp_vec(0));
         end
         tick();
      end
      n_cmp++;
      if (c0 !== 32'd3 || c1 !== 2'd2) begin
         n_err++; $display("FAIL b2b_count: cnt=%0d/%0d want 3/2", c0, c1);
      end
   endtask

   task automatic test_zero_reg();
      do_reset();
      set(0, 0, 0, 0, 0, 0, 1, 0);
      tick();
      set(0, 0, 1, 0, 1, 0, 1, 7);
      n_cmp++;
      if ({s0, h0, st0} !== 4'd0 || {s1, h1, st1} !== 4'd0) begin
         n_err++; $display("FAIL zero_reg: d0 %b/%b/%0d d1 %b/%b/%0d want 0", s0, h0, st0, s1, h1, st1);
      end
      tick();
      set(0, 0, 0, 7, 0, 7, 0, 0);
      n_cmp++;
      if ({s0, h0, st0} !== 4'd0 || {s1, h1, st1} !== 4'd0) begin
         n_err++; $display("FAIL no_reads: d0 %b/%b/%0d d1 %b/%b/%0d want 0", s0, h0, st0, s1, h1, st1);
      end
   endtask

   task automatic test_gap();
      logic es0, es1;
      logic [1:0] est0, est1;
      do_reset();
      set(0, 0, 0, 0, 0, 0, 1, 5);
      tick();
      set(0, 0, 1, 9, 0, 0, 0, 0);
      tick();
      for (int c = 0; c < 3; c++) begin
         set(0, 0, 0, 5, 1, 5, 1, 6);
         es0 = c < 2; est0 = c == 0 ? 2'd2 : c == 1 ? 2'd3 : 2'd0;
         es1 = c < 1; est1 = c == 0 ? 2'd2 : 2'd0;
         n_cmp++;
         if (s0 !== es0 || st0 !== est0 || s1 !== es1 || st1 !== est1) begin
            n_err++; $display("FAIL gap c%0d: d0 %b/%0d want %b/%0d, d1 %b/%0d want %b/%0d",
                              c, s0, st0, es0, est0, s1, st1, es1, est1);
         end
         tick();
      end
      n_cmp++;
      if (c0 !== 32'd2 || c1 !== 2'd1) begin
         n_err++; $display("FAIL gap_count: cnt=%0d/%0d want 2/1", c0, c1);
      end
   endtask

   task automatic test_mem_busy();
      do_reset();
      set(0, 0, 0, 0, 0, 0, 1, 1);
      tick();
      set(0, 0, 1, 1, 1, 1, 1, 2);
      tick();
      for (int c = 0; c < 4; c++) begin
         set(0, 1, 1, 1, 1, 1, 1, 2);
         n_cmp++;
         if (f0 !== 1'b1 || s0 !== 1'b0 || h0 !== 1'b1 || st0 !== 2'd2 || c0 !== 32'd1) begin
            n_err++; $display("FAIL busy c%0d: freeze=%b stall=%b hold=%b stage=%0d cnt=%0d want 1/0/1/2/1",
                              c, f0, s0, h0, st0, c0);
         end
         tick();
      end
      for (int c = 0; c < 3; c++) begin
         set(0, 0, 1, 1, 1, 1, 1, 2);
         n_cmp++;
         if ({s0, h0, f0, st0} !== exp_vec(0) || {s1, h1, f1, st1} !== exp_vec(1)) begin
            n_err++; $display("FAIL busy_resume c%0d: got %b/%b want %b/%b", c,
                              {s0, h0, f0, st0}, {s1, h1, f1, st1}, exp_vec(0), exp_vec(1));
         end
         tick();
      end
      n_cmp++;
      if (c0 !== 32'd3 || c1 !== 2'd2) begin
         n_err++; $display("FAIL busy_count: cnt=%0d/%0d want 3/2", c0, c1);
      end
   endtask

   task automatic test_saturate();
      do_reset();
      for (int p = 0; p < 2; p++) begin
         set(0, 0, 0, 0, 0, 0, 1, 5'(p + 1));
         tick();
         for (int c = 0; c < 4; c++) begin
            set(0, 0, 1, 5'(p + 1), 1, 5'(p + 1), 1, 5'(p + 10));
            tick();
            n_cmp++;
            if (c1 !== 2'(m_cnt[1])) begin
               n_err++; $display("FAIL sat_track p%0d c%0d: cnt=%0d want %0d", p, c, c1, m_cnt[1]);
            end
         end
      end
      n_cmp++;
      if (c1 !== 2'd3 || c0 !== 32'd6) begin
         n_err++; $display("FAIL saturate: cnt=%0d/%0d want 6/3", c0, c1);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      set(0, 0, 0, 0, 0, 0, 1, 1);
      tick();
      set(1, 0, 1, 1, 1, 1, 1, 2);
      n_cmp++;
      if (s0 !== 1'b1) begin
         n_err++; $display("FAIL rst_mid_pre: stall=%b want 1", s0);
      end
      tick();
      set(0, 0, 1, 1, 1, 1, 1, 2);
      n_cmp++;
      if (s0 !== 1'b0 || s1 !== 1'b0 || c0 !== 32'd0 || c1 !== 2'd0 || st0 !== 2'd0) begin
         n_err++; $display("FAIL rst_mid: stall=%b/%b stage=%0d cnt=%0d/%0d want 0", s0, s1, st0, c0, c1);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         set($urandom_range(39) == 0, $urandom_range(5) == 0, 1'($urandom), 5'($urandom_range(5)),
             1'($urandom), 5'($urandom_range(5)), 1'($urandom), 5'($urandom_range(5)));
         n_cmp++;
         if ({s0, h0, f0, st0} !== exp_vec(0) || {s1, h1, f1, st1} !== exp_vec(1) ||
             c0 !== 32'(m_cnt[0]) || c1 !== 2'(m_cnt[1])) begin
            n_err++; $display("FAIL random i%0d: d0 %b cnt %0d want %b cnt %0d; d1 %b cnt %0d want %b cnt %0d",
                              i, {s0, h0, f0, st0}, c0, exp_vec(0), m_cnt[0],
                              {s1, h1, f1, st1}, c1, exp_vec(1), m_cnt[1]);
         end
         tick();
      end
   endtask

   initial begin
      set(1, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      test_reset();
      test_back_to_back();
      test_zero_reg();
      test_gap();
      test_mem_busy();
      test_saturate();
      test_reset_mid();
      do_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
